// File: rtl/prim_width_adapt_pipe.sv
// Multi-lane width adapter (extend / truncate / saturate) feeding a 2-entry FIFO.
// Also keeps a sticky, clearable count of accepted items that had a clamped lane.

module prim_width_adapt_lane #(
    parameter int InWidth  = 8,
    parameter int OutWidth = 16
) (
    input  logic [InWidth-1:0]  data_i,
    input  logic [1:0]          mode_i,
    output logic [OutWidth-1:0] data_o,
    output logic                sat_o
);
    if (OutWidth > InWidth) begin : g_widen
        // mode[0] selects sign extension; saturation can never trigger when widening
        logic unused_mode;
        assign unused_mode = mode_i[1];
        assign data_o = {{(OutWidth-InWidth){mode_i[0] & data_i[InWidth-1]}}, data_i};
        assign sat_o  = 1'b0;
    end else if (OutWidth == InWidth) begin : g_pass
        logic unused_mode;
        assign unused_mode = ^mode_i;
        assign data_o = data_i;
        assign sat_o  = 1'b0;
    end else begin : g_narrow
        logic msb, ovf_u, ovf_s;
        assign msb   = data_i[InWidth-1];
        assign ovf_u = |data_i[InWidth-1:OutWidth];
        // Signed value fits only if all dropped bits equal the kept sign bit
        assign ovf_s = data_i[InWidth-1:OutWidth-1] != {(InWidth-OutWidth+1){msb}};

        always_comb begin
            data_o = data_i[OutWidth-1:0];
            sat_o  = 1'b0;
            case (mode_i)
                2'b10: if (ovf_u) begin
                    data_o = '1;
                    sat_o  = 1'b1;
                end
                2'b11: if (ovf_s) begin
                    data_o = {msb, {(OutWidth-1){~msb}}};
                    sat_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

module prim_width_adapt_pipe #(
    parameter int InWidth  = 8,
    parameter int OutWidth = 16,
    parameter int NumLanes = 1,
    parameter int CntWidth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [NumLanes*InWidth-1:0]  data_i,
    input  logic [1:0]                   mode_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [NumLanes*OutWidth-1:0] data_o,
    output logic [NumLanes-1:0]          sat_o,
    output logic [CntWidth-1:0]          sat_cnt_o,
    input  logic                         clr_cnt_i
);
    typedef struct packed {
        logic [NumLanes-1:0][OutWidth-1:0] data;
        logic [NumLanes-1:0]               sat;
    } entry_t;

    logic [NumLanes-1:0][InWidth-1:0]  lane_in;
    logic [NumLanes-1:0][OutWidth-1:0] lane_out;
    logic [NumLanes-1:0]               lane_sat;

    assign lane_in = data_i;

    for (genvar k = 0; k < NumLanes; k++) begin : g_lane
        prim_width_adapt_lane #(
            .InWidth (InWidth),
            .OutWidth(OutWidth)
        ) u_lane (
            .data_i(lane_in[k]),
            .mode_i(mode_i),
            .data_o(lane_out[k]),
            .sat_o (lane_sat[k])
        );
    end

    entry_t [1:0] mem;
    logic         wr_ptr, rd_ptr;
    logic [1:0]   count, count_next;
    logic         ready_q, valid_q;
    logic         push, pop, cnt_inc;

    assign push    = valid_i & ready_q;
    assign pop     = valid_q & ready_i;
    assign cnt_inc = push & (|lane_sat);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem     <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{data: lane_out, sat: lane_sat};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count   <= count_next;
            ready_q <= count_next != 2'd2;
            valid_q <= count_next != 2'd0;
        end
    end

    // Counts at acceptance, so backpressure downstream never affects it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            sat_cnt_o <= cnt_inc ? CntWidth'(1) : '0;
        end else if (cnt_inc && sat_cnt_o != '1) begin
            sat_cnt_o <= sat_cnt_o + CntWidth'(1);
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign data_o  = mem[rd_ptr].data;
    assign sat_o   = mem[rd_ptr].sat;
endmodule

// File: tb/tb_prim_width_adapt_pipe.sv
// Two adapters share one handshake: A widens 8->16 (1 lane), B narrows 8->4 (2 lanes, 2-bit counter).
// A queue-based reference model predicts both outputs every cycle.

module tb_prim_width_adapt_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0, ready_i = 1'b0, clr = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00;
    logic [15:0] data_b_in;

    logic        ready_a, valid_a;
    logic [15:0] dout_a;
    logic [0:0]  sat_a;
    logic [7:0]  cnt_a;
    logic        ready_b, valid_b;
    logic [7:0]  dout_b;
    logic [1:0]  sat_b;
    logic [1:0]  cnt_b;

    int nchk = 0, nerr = 0;

    assign data_b_in = {d1, d0};

    always #5 clk = ~clk;

    prim_width_adapt_pipe #(.InWidth(8), .OutWidth(16), .NumLanes(1), .CntWidth(8)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_a), .data_i(d0),
        .mode_i(mode), .valid_o(valid_a), .ready_i(ready_i), .data_o(dout_a), .sat_o(sat_a),
        .sat_cnt_o(cnt_a), .clr_cnt_i(clr)
    );

    prim_width_adapt_pipe #(.InWidth(8), .OutWidth(4), .NumLanes(2), .CntWidth(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_b), .data_i(data_b_in),
        .mode_i(mode), .valid_o(valid_b), .ready_i(ready_i), .data_o(dout_b), .sat_o(sat_b),
        .sat_cnt_o(cnt_b), .clr_cnt_i(clr)
    );

    typedef struct {
        int qa;
        bit sa;
        int qb0;
        int qb1;
        bit sb0;
        bit sb1;
    } exp_t;

    exp_t exp_q[$];
    int   mcnt_a = 0, mcnt_b = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion straight from the arithmetic rules of each mode
    function automatic void conv(input int iw, input int ow, input int d, input int m,
                                 output int q, output bit s);
        int big, half, sv;
        big  = 1 << ow;
        half = big / 2;
        sv   = (d >= (1 << (iw - 1))) ? d - (1 << iw) : d;
        s    = 1'b0;
        case (m)
            0: q = d % big;
            1: q = ((sv % big) + big) % big;
            2: if (d > big - 1) begin q = big - 1; s = 1'b1; end
               else q = d;
            default: begin
                if (sv > half - 1)   begin q = half - 1; s = 1'b1; end
                else if (sv < -half) begin q = half;     s = 1'b1; end
                else q = ((sv % big) + big) % big;
            end
        endcase
    endfunction

    function automatic int cnt_next(input int cur, input int maxv, input bit inc, input bit c);
        if (c) return inc ? 1 : 0;
        if (inc && cur < maxv) return cur + 1;
        return cur;
    endfunction

    // Monitor: compares what the DUTs show now, then advances the model for the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            mcnt_a = 0;
            mcnt_b = 0;
            chk("rst_valid_a", int'(valid_a), 0);
            chk("rst_ready_a", int'(ready_a), 1);
            chk("rst_data_a",  int'(dout_a), 0);
            chk("rst_cnt_a",   int'(cnt_a), 0);
            chk("rst_valid_b", int'(valid_b), 0);
            chk("rst_ready_b", int'(ready_b), 1);
            chk("rst_data_b",  int'(dout_b), 0);
            chk("rst_sat_b",   int'(sat_b), 0);
            chk("rst_cnt_b",   int'(cnt_b), 0);
        end else begin
            bit   can_push, do_pop;
            exp_t e;
            can_push = exp_q.size() < 2;
            do_pop   = (exp_q.size() > 0) && ready_i;
            chk("ready_a", int'(ready_a), int'(can_push));
            chk("ready_b", int'(ready_b), int'(can_push));
            chk("valid_a", int'(valid_a), int'(exp_q.size() > 0));
            chk("valid_b", int'(valid_b), int'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("data_a", int'(dout_a), exp_q[0].qa);
                chk("sat_a",  int'(sat_a), int'(exp_q[0].sa));
                chk("data_b", int'(dout_b), exp_q[0].qb1 * 16 + exp_q[0].qb0);
                chk("sat_b",  int'(sat_b), int'(exp_q[0].sb1) * 2 + int'(exp_q[0].sb0));
            end
            chk("cnt_a", int'(cnt_a), mcnt_a);
            chk("cnt_b", int'(cnt_b), mcnt_b);
            if (do_pop) void'(exp_q.pop_front());
            if (valid_i && can_push) begin
                conv(8, 16, int'(d0), int'(mode), e.qa, e.sa);
                conv(8, 4, int'(d0), int'(mode), e.qb0, e.sb0);
                conv(8, 4, int'(d1), int'(mode), e.qb1, e.sb1);
                exp_q.push_back(e);
                mcnt_a = cnt_next(mcnt_a, 255, e.sa, clr);
                mcnt_b = cnt_next(mcnt_b, 3, e.sb0 | e.sb1, clr);
            end else begin
                mcnt_a = cnt_next(mcnt_a, 255, 1'b0, clr);
                mcnt_b = cnt_next(mcnt_b, 3, 1'b0, clr);
            end
        end
    end

    task automatic drive(input bit v, input bit r, input logic [1:0] m,
                         input logic [7:0] a, input logic [7:0] b, input bit c);
        @(posedge clk);
        #1;
        valid_i = v;
        ready_i = r;
        mode    = m;
        d0      = a;
        d1      = b;
        clr     = c;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Widening examples (A) and narrowing examples (B)
        drive(1, 1, 2'b01, 8'h80, 8'h00, 0);
        drive(1, 1, 2'b00, 8'h80, 8'h00, 0);
        drive(1, 1, 2'b11, 8'h7F, 8'h00, 0);
        drive(1, 1, 2'b11, 8'h80, 8'h00, 0);
        drive(1, 1, 2'b11, 8'hFE, 8'h00, 0);
        drive(1, 1, 2'b10, 8'h1F, 8'h00, 0);
        drive(1, 1, 2'b00, 8'h1F, 8'h00, 0);
        drive(0, 1, 2'b00, 8'h00, 8'h00, 1);
        drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Backpressure: third push must be ignored, head stays stable
        drive(1, 0, 2'b01, 8'hA5, 8'h11, 0);
        drive(1, 0, 2'b01, 8'h5A, 8'h22, 0);
        drive(1, 0, 2'b01, 8'hC3, 8'h33, 0);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        repeat (3) drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Streaming at full rate
        for (int i = 0; i < 10; i++)
            drive(1, 1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 0);
        repeat (2) drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Counter saturation, then clear coinciding with a counted push
        drive(0, 1, 2'b00, 8'h00, 8'h00, 1);
        repeat (5) drive(1, 1, 2'b11, 8'h7F, 8'h00, 0);
        drive(1, 1, 2'b11, 8'h7F, 8'h00, 1);
        drive(1, 1, 2'b11, 8'h7F, 8'h01, 0);
        repeat (2) drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Reset with two items buffered
        drive(1, 0, 2'b00, 8'h12, 8'h34, 0);
        drive(1, 0, 2'b00, 8'h56, 8'h78, 0);
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid_a", int'(valid_a), 0);
        chk("async_rst_valid_b", int'(valid_b), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 1, 2'b00, 8'h00, 8'h00, 0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 15) == 0));

        // Drain with a bounded wait
        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                drive(0, 1, 2'b00, 8'h00, 8'h00, 0);
                budget--;
            end
            chk("drain_timeout", exp_q.size(), 0);
        end
        drive(0, 0, 2'b00, 8'h00, 8'h00, 0);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
